// File: rtl/restoring_divider_pkg.sv
// Shared arithmetic-unit package (calc_pkg): divider FSM state encoding and
// the bit-counter width used by the restoring divider.
package calc_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Default operand width and matching counter width
    localparam int DIV_N     = 4;
    localparam int DIV_CNT_W = $clog2(DIV_N);

    // Counter width for an n-bit divider; never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// Start/done handshake bundle between the calculator control FSM (master)
// and the restoring divider (slave).
interface restoring_divider_if #(parameter int N = 4);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_sub.sv
// borrow_lookahead_sub: combinational a - b using propagate/generate borrow
// lookahead, the subtractive twin of the adder's carry-lookahead network.
module borrow_lookahead_sub #(parameter int N = 5) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout
);
    logic [N-1:0] gen_s;
    logic [N-1:0] prop_s;
    logic [N:0]   borrow_s;
    logic         prod_s;

    // A bit generates a borrow when it is 0 and the subtrahend bit is 1;
    // it passes an incoming borrow through when both bits are equal.
    assign gen_s  = ~a & b;
    assign prop_s = ~(a ^ b);

    // Flattened lookahead: borrow into bit i+1 is any generate at j<=i
    // propagated through every bit above it up to i.
    always_comb begin
        borrow_s = '0;
        prod_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j <= i; j++) begin
                prod_s = gen_s[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod_s = prod_s & prop_s[k];
                end
                borrow_s[i+1] = borrow_s[i+1] | prod_s;
            end
        end
    end

    assign diff = a ^ b ^ borrow_s[N-1:0];
    assign bout = borrow_s[N];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential N-bit restoring divider, one quotient bit per
// clock, start/done handshake. Define DIVIDER_SIGNED_EN for two's-complement
// operands (magnitude division plus sign fix-up at result load).
module restoring_divider
    import calc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    restoring_divider_if.slave   bus
);
    localparam int             CW       = cnt_width(N);
    localparam logic [CW-1:0]  LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [N-1:0]   ONE_N    = {{(N-1){1'b0}}, 1'b1};

    div_state_e    state_q;
    logic [N:0]    rem_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  divisor_q;
    logic [CW-1:0] cnt_q;
    logic          neg_quo_q;
    logic          neg_rem_q;
    logic          busy_q;
    logic          done_q;
    logic          dbz_q;
    logic [N-1:0]  quotient_q;
    logic [N-1:0]  remainder_q;

    logic [N:0]    shifted_s;
    logic [N:0]    diff_s;
    logic          bout_s;
    logic [N:0]    rem_d;
    logic [N-1:0]  quo_d;
    logic [N-1:0]  dividend_mag_s;
    logic [N-1:0]  divisor_mag_s;
    logic          neg_quo_s;
    logic          neg_rem_s;
    logic [N-1:0]  quotient_d;
    logic [N-1:0]  remainder_d;

    // Trial subtraction of the divisor from the shifted partial remainder
    assign shifted_s = {rem_q[N-1:0], quo_q[N-1]};

    borrow_lookahead_sub #(.N(N + 1)) u_sub (
        .a    (shifted_s),
        .b    ({1'b0, divisor_q}),
        .diff (diff_s),
        .bout (bout_s)
    );

    // Restore on borrow, otherwise keep the difference and shift in a 1
    always_comb begin
        rem_d = shifted_s;
        quo_d = {quo_q[N-2:0], 1'b0};
        if (!bout_s) begin
            rem_d = diff_s;
            quo_d = {quo_q[N-2:0], 1'b1};
        end else begin
            rem_d = shifted_s;
            quo_d = {quo_q[N-2:0], 1'b0};
        end
    end

`ifdef DIVIDER_SIGNED_EN
    // Operand magnitudes and result signs for two's-complement division
    always_comb begin
        dividend_mag_s = bus.dividend;
        divisor_mag_s  = bus.divisor;
        if (bus.dividend[N-1]) begin
            dividend_mag_s = ~bus.dividend + ONE_N;
        end else begin
            dividend_mag_s = bus.dividend;
        end
        if (bus.divisor[N-1]) begin
            divisor_mag_s = ~bus.divisor + ONE_N;
        end else begin
            divisor_mag_s = bus.divisor;
        end
        neg_quo_s = bus.dividend[N-1] ^ bus.divisor[N-1];
        neg_rem_s = bus.dividend[N-1];
    end
`else
    // Unsigned operands pass straight through with no sign fix-up
    always_comb begin
        dividend_mag_s = bus.dividend;
        divisor_mag_s  = bus.divisor;
        neg_quo_s      = 1'b0;
        neg_rem_s      = 1'b0;
    end
`endif

    // Final-iteration results with sign fix-up applied as they are loaded
    always_comb begin
        quotient_d  = quo_d;
        remainder_d = rem_d[N-1:0];
        if (neg_quo_q) begin
            quotient_d = ~quo_d + ONE_N;
        end else begin
            quotient_d = quo_d;
        end
        if (neg_rem_q) begin
            remainder_d = ~rem_d[N-1:0] + ONE_N;
        end else begin
            remainder_d = rem_d[N-1:0];
        end
    end

    // Control FSM, iteration registers and registered handshake/results
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            quo_q       <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        divisor_q <= divisor_mag_s;
                        quo_q     <= dividend_mag_s;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        neg_quo_q <= neg_quo_s;
                        neg_rem_q <= neg_rem_s;
                        if (bus.divisor == '0) begin
                            // No iteration: results are defined directly
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dbz_q       <= 1'b0;
                        quotient_q  <= quotient_d;
                        remainder_q <= remainder_d;
                    end else begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule
